// File: rtl/countdown_preset_ctrl.sv
// Keypad-driven front end for a cascaded BCD down-counter chain: collects a preset,
// loads the chain, gates the count enable and flags completion when the chain hits zero.
module countdown_preset_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  clrn_i,
    input  logic                  key_valid_i,
    input  logic [3:0]            key_code_i,
    input  logic                  tick_i,
    input  logic                  chain_zero_i,
    output logic [4*DIGITS-1:0]   cnt_in_o,
    output logic                  loadn_o,
    output logic                  cnt_clrn_o,
    output logic                  cnt_en_o,
    output logic                  running_o,
    output logic                  done_o
);

    typedef enum logic [2:0] {
        StIdle,
        StEntry,
        StLoad,
        StRun,
        StPause,
        StDone
    } state_e;

    localparam logic [3:0] KeyStart = 4'hA;
    localparam logic [3:0] KeyStop  = 4'hB;
    localparam logic [3:0] KeyClear = 4'hC;

    state_e              state_q;
    logic [4*DIGITS-1:0] preset_q;
    logic [4*DIGITS-1:0] preset_shl;
    logic [3:0]          entry_cnt_q;
    logic                loadn_q;
    logic                cnt_clrn_q;
    logic                running_q;
    logic                done_q;

    logic key_digit;
    logic key_start;
    logic key_stop;
    logic key_clear;
    logic do_clear;

    generate
        if (DIGITS == 1) begin : g_shl_one
            assign preset_shl = key_code_i;
        end else begin : g_shl_multi
            assign preset_shl = {preset_q[4*DIGITS-5:0], key_code_i};
        end
    endgenerate

    always_comb begin
        key_digit = key_valid_i && (key_code_i <= 4'd9);
        key_start = key_valid_i && (key_code_i == KeyStart);
        key_stop  = key_valid_i && (key_code_i == KeyStop);
        key_clear = key_valid_i && (key_code_i == KeyClear);
        // Clear is honoured everywhere except LOAD; in RUN a zero chain outranks any key,
        // and in DONE start behaves as clear.
        do_clear = 1'b0;
        unique case (state_q)
            StIdle, StEntry, StPause: do_clear = key_clear;
            StRun:                    do_clear = key_clear && !chain_zero_i;
            StDone:                   do_clear = key_clear || key_start;
            default:                  do_clear = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            state_q     <= StIdle;
            preset_q    <= '0;
            entry_cnt_q <= '0;
            loadn_q     <= 1'b1;
            cnt_clrn_q  <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            loadn_q    <= 1'b1;
            cnt_clrn_q <= 1'b1;
            if (do_clear) begin
                state_q     <= StIdle;
                preset_q    <= '0;
                entry_cnt_q <= '0;
                cnt_clrn_q  <= 1'b0;
                running_q   <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StEntry: begin
                        if (key_digit) begin
                            if (entry_cnt_q < 4'(DIGITS)) begin
                                preset_q    <= preset_shl;
                                entry_cnt_q <= entry_cnt_q + 4'd1;
                                state_q     <= StEntry;
                            end
                        end else if (key_start && (preset_q != '0)) begin
                            state_q <= StLoad;
                            loadn_q <= 1'b0;
                        end
                    end
                    StLoad: begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end
                    StRun: begin
                        if (chain_zero_i) begin
                            state_q   <= StDone;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else if (key_stop) begin
                            state_q   <= StPause;
                            running_q <= 1'b0;
                        end
                    end
                    StPause: begin
                        if (key_start) begin
                            state_q   <= StRun;
                            running_q <= 1'b1;
                        end
                    end
                    StDone: begin
                        done_q <= 1'b1;
                    end
                    default: begin
                        state_q   <= StIdle;
                        running_q <= 1'b0;
                        done_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Gated by the chain flag so the counters never wrap past all-zero.
    assign cnt_en_o   = (state_q == StRun) && tick_i && !chain_zero_i;
    assign cnt_in_o   = preset_q;
    assign loadn_o    = loadn_q;
    assign cnt_clrn_o = cnt_clrn_q;
    assign running_o  = running_q;
    assign done_o     = done_q;

endmodule
